data_mem_access: RTL
====================

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the bus-ack wait limit in cycles before a timeout.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-004 Port mem_read, input, 1, SHALL mark a load request from the MEM stage.
REQ-005 Port mem_write, input, 1, SHALL be the store request, driven by the decoder's memWrite.
REQ-006 Port datasize, input, 2, SHALL give access width: 00 byte, 01 half, 11 word; 10 is treated as word.
REQ-007 Port is_unsigned, input, 1, SHALL select a zero-extended load (opcode bit 2, lbu/lhu).
REQ-008 Port addr, input, 32, SHALL give the byte address from the ALU.
REQ-009 Port store_data, input, 32, SHALL carry the rt value; right-justified for byte and half stores.
REQ-010 Port load_data, output, 32, SHALL carry the extended load result, valid while done=1.
REQ-011 Port stall, output, 1, SHALL freeze the pipeline while an access is pending.
REQ-012 Port done, output, 1, SHALL be a one-cycle completion pulse.
REQ-013 Port bus_err, output, 1, SHALL pulse with done when an access times out.
REQ-014 Port align_err, output, 1, SHALL pulse with done when an access is misaligned.
REQ-015 Ports bus_req/bus_we (out, 1), bus_addr (out, 32), bus_be (out, 4) and bus_wdata (out, 32) SHALL form the word-memory request.
REQ-016 Ports bus_rdata (in, 32) and bus_ack (in, 1) SHALL form the word-memory response.

Function
REQ-017 FSM states SHALL be IDLE, BUS and DONE.
REQ-018 IDLE: when mem_read or mem_write is high, stall SHALL be 1 combinationally, operands SHALL be registered, and the next state SHALL be BUS, or DONE on an alignment error.
REQ-019 BUS: bus_req SHALL be 1 and stall SHALL be 1; bus_addr SHALL be {addr[31:2],2'b00}; bus_we SHALL equal the registered write flag.
REQ-020 BUS with bus_ack=1: bus_rdata SHALL be captured and the next state SHALL be DONE, giving a minimum latency of 2 stalled cycles plus the DONE cycle.
REQ-021 DONE: stall SHALL be 0, done SHALL be 1, and the next state SHALL be IDLE; back-to-back accesses therefore restart from IDLE.
REQ-022 Byte lanes SHALL be big-endian: byte offset 0 maps to bits 31:24.
REQ-023 Byte enables SHALL be: byte access 1000>>addr[1:0]; half access 1100 (addr[1]=0) or 0011 (addr[1]=1); word access 1111.
REQ-024 bus_wdata SHALL replicate the store byte or half across all lanes.
REQ-025 A load SHALL select its lane and sign-extend, or zero-extend when is_unsigned=1; for a store, load_data SHALL be 0.
REQ-026 With mem_read=1 and mem_write=1 together, the write SHALL take priority.
REQ-027 A wait counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-028 When the wait counter reaches MAX_WAIT, the next state SHALL be DONE with bus_err=1 and load_data=0.
REQ-029 When bus_ack arrives in the same cycle the counter reaches MAX_WAIT, the ack SHALL win and bus_err SHALL stay 0.
REQ-030 When state is not BUS, bus_req SHALL be 0 and bus_be SHALL be 0000.

Reset
REQ-031 Reset SHALL force state IDLE and clear the counter and all registers.
REQ-032 During and after reset: stall, done, bus_err, align_err and bus_req SHALL be 0, and load_data SHALL be 0.
REQ-033 Reset asserted mid-access SHALL abandon the access, with no done pulse; bus_req SHALL drop in the following cycle.

Configuration
REQ-034 With macro MEM_ALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip BUS, pulse align_err in DONE, and return load_data=0.
REQ-035 Without MEM_ALIGN_CHECK_EN, align_err SHALL be tied to 0 and ignored address bits SHALL be truncated (half uses addr[1]; word ignores addr[1:0]).

Structure
REQ-036 The datasize encodings, FSM state encodings and byte-enable constants SHALL reside in shared package mips_mem_pkg.
REQ-037 Lane selection and extension SHALL live in combinational sub-module load_align (inputs: word, offset, size, is_unsigned).

Verification
REQ-038 sb, addr=0x103, store_data=0x000000AB, ack after 1 cycle -> bus_be=0001, bus_wdata=0xABABABAB, done on cycle 3.
REQ-039 lb, addr=0x101, bus_rdata=0x1280FF00 -> load_data=0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-040 lh, addr=0x102, bus_rdata=0x0000F00D -> load_data=0xFFFFF00D with bus_be=0011.
REQ-041 lw and bus_ack never asserted, MAX_WAIT=15 -> bus_err and done pulse together, load_data=0, stall released.
REQ-042 sw, addr=0x102, MEM_ALIGN_CHECK_EN defined -> no bus_req, align_err=1 on cycle 2; without the macro -> bus_be=1111, bus_addr=0x100.
REQ-043 reset asserted during BUS of an lw -> no done pulse; bus_req=0 next cycle; a new lw afterwards completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM-stage data memory access block:
//   - size_e   : datasize encodings (00 byte, 01 half, 10 reserved, 11 word)
//   - state_e  : access FSM state encodings (IDLE, BUS, DONE)
//   - BE_*     : big-endian byte-enable constants (bit 3 = byte offset 0)
//   - helpers  : size normalisation, byte-enable and store-lane replication,
//                alignment test (used only when MEM_ALIGN_CHECK_EN is defined)
// No ports (package).
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // The reserved encoding behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] ds);
    size_e sz;
    case (ds)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // Lane enables; unaligned low address bits are simply truncated here.
  function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = BE_BYTE0 >> off;
      SZ_HALF: be = off[1] ? BE_HALF_LO : BE_HALF_HI;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Store data is right-justified in rt; copy it onto every lane so the
  // byte enables alone pick the target bytes.
  function automatic logic [31:0] replicate_wdata(input size_e sz, input logic [31:0] sd);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{sd[7:0]}};
      SZ_HALF: w = {2{sd[15:0]}};
      default: w = sd;
    endcase
    return w;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_access_if.sv
// -----------------------------------------------------------------------------
// data_mem_access_if
// Word-memory request/response bus between data_mem_access and the memory.
//   bus_req   : access request, held while the access is outstanding
//   bus_we    : 1 = store, 0 = load
//   bus_addr  : word-aligned byte address
//   bus_be    : big-endian byte enables (bit 3 = byte offset 0)
//   bus_wdata : store data, replicated across lanes
//   bus_rdata : load word returned by memory
//   bus_ack   : response strobe, one cycle
// Modports: master (access unit side), slave (memory side).
// -----------------------------------------------------------------------------
interface data_mem_access_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load lane selection and extension (big-endian lanes).
//   word        : 32-bit word read from memory
//   offset      : byte offset addr[1:0] of the access
//   size        : access width (reserved encoding treated as word)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : extended, right-justified load result
// -----------------------------------------------------------------------------
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte/half, then extend according to width and signedness.
  always_comb begin
    lane_byte = 8'h00;
    lane_half = 16'h0000;
    data      = 32'h0000_0000;

    case (offset)
      2'b00:   lane_byte = word[31:24];
      2'b01:   lane_byte = word[23:16];
      2'b10:   lane_byte = word[15:8];
      2'b11:   lane_byte = word[7:0];
      default: lane_byte = 8'h00;
    endcase

    if (offset[1]) begin
      lane_half = word[15:0];
    end else begin
      lane_half = word[31:16];
    end

    case (size)
      SZ_BYTE: begin
        if (is_unsigned) begin
          data = {24'h00_0000, lane_byte};
        end else begin
          data = {{24{lane_byte[7]}}, lane_byte};
        end
      end
      SZ_HALF: begin
        if (is_unsigned) begin
          data = {16'h0000, lane_half};
        end else begin
          data = {{16{lane_half[15]}}, lane_half};
        end
      end
      SZ_RSVD: data = word;
      SZ_WORD: data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// -----------------------------------------------------------------------------
// data_mem_access
// MEM-stage data memory access unit: turns a load/store request into one
// word-bus transaction, stalls the pipeline while it is pending and returns
// the extended load result with a one-cycle done pulse.
// Parameter:
//   MAX_WAIT    : BUS cycles without ack tolerated before a timeout (bus_err)
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   mem_read    : load request          mem_write  : store request (wins)
//   datasize    : 00 byte, 01 half, 1x word
//   is_unsigned : zero-extend loads     addr       : byte address
//   store_data  : right-justified store value
//   load_data   : extended load result, valid while done=1, else 0
//   stall       : pipeline freeze while the access is pending
//   done        : one-cycle completion pulse
//   bus_err     : timeout, pulses with done
//   align_err   : misaligned access, pulses with done
//   bus         : data_mem_access_if master modport (word-memory bus)
// Configuration:
//   MEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses skip the
//                        bus and report align_err; otherwise align_err is 0
//                        and unused low address bits are truncated.
// -----------------------------------------------------------------------------
module data_mem_access
  import mips_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [1:0]               datasize,
  input  logic                     is_unsigned,
  input  logic [31:0]              addr,
  input  logic [31:0]              store_data,
  output logic [31:0]              load_data,
  output logic                     stall,
  output logic                     done,
  output logic                     bus_err,
  output logic                     align_err,
  data_mem_access_if.master        bus
);

  localparam int                WAIT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_e            state_q,     state_d;
  logic [WAIT_W-1:0] wait_q,      wait_d;
  logic              we_q,        we_d;
  size_e             size_q,      size_d;
  logic              uns_q,       uns_d;
  logic [1:0]        off_q,       off_d;
  logic [29:0]       waddr_q,     waddr_d;
  logic [3:0]        be_q,        be_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              done_q,      done_d;
  logic              bus_err_q,   bus_err_d;
  logic              align_err_q, align_err_d;
  logic [31:0]       load_data_q, load_data_d;

  logic              busy;
  logic              misaligned;
  size_e             req_size;
  logic [31:0]       aligned_data;

  assign req_size = norm_size(datasize);

  // Misalignment is only detected when the check is built in.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = is_misaligned(req_size, addr[1:0]);
`else
    misaligned = 1'b0;
`endif
  end

  load_align u_load_align (
    .word        (bus.bus_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (aligned_data)
  );

  // Next-state and completion flags; status flags are set on entry to DONE.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    waddr_d     = waddr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    load_data_d = 32'h0000_0000;
    busy        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          busy    = 1'b1;
          we_d    = mem_write;
          size_d  = req_size;
          uns_d   = is_unsigned;
          off_d   = addr[1:0];
          waddr_d = addr[31:2];
          be_d    = byte_enable(req_size, addr[1:0]);
          wdata_d = replicate_wdata(req_size, store_data);
          wait_d  = {WAIT_W{1'b0}};
          if (misaligned) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            align_err_d = 1'b1;
          end else begin
            state_d = ST_BUS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS: begin
        busy = 1'b1;
        // An ack in the limit cycle still counts as success.
        if (bus.bus_ack) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          wait_d  = {WAIT_W{1'b0}};
          if (we_q) begin
            load_data_d = 32'h0000_0000;
          end else begin
            load_data_d = aligned_data;
          end
        end else if (wait_q == WAIT_LIMIT) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          wait_d    = {WAIT_W{1'b0}};
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= {WAIT_W{1'b0}};
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      waddr_q     <= 30'h0000_0000;
      be_q        <= BE_NONE;
      wdata_q     <= 32'h0000_0000;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      waddr_q     <= waddr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
      load_data_q <= load_data_d;
    end
  end

  // Stall is combinational so the request cycle itself is frozen; it is
  // masked while reset is held so a reset never looks like a pending access.
  assign stall     = busy & ~reset;
  assign done      = done_q;
  assign bus_err   = bus_err_q;
  assign align_err = align_err_q;
  assign load_data = load_data_q;

  // Bus fields are only driven while a request is outstanding.
  assign bus.bus_req   = (state_q == ST_BUS);
  assign bus.bus_we    = (state_q == ST_BUS) ? we_q : 1'b0;
  assign bus.bus_addr  = (state_q == ST_BUS) ? {waddr_q, 2'b00} : 32'h0000_0000;
  assign bus.bus_be    = (state_q == ST_BUS) ? be_q : BE_NONE;
  assign bus.bus_wdata = (state_q == ST_BUS) ? wdata_q : 32'h0000_0000;

endmodule
